// File: rtl/uni_mem_arb_pkg.sv
// Shared definitions for the unified memory request arbiter slice.
// Request-type encodings, master indices and arbiter state type.
package uni_mem_arb_pkg;

  localparam int unsigned ADR_WIDTH = 32;

  localparam logic REQ_RD = 1'b0;
  localparam logic REQ_WR = 1'b1;

  // Master index as stored in owner/last
  localparam logic OWN_D = 1'b0;
  localparam logic OWN_I = 1'b1;

  typedef enum logic {
    ARB_IDLE,
    ARB_BUSY
  } arb_state_t;

endpackage

// File: rtl/uni_rr_pick2.sv
// Combinational 2-way round-robin selector: a lone requester wins,
// on a tie the master that was not served last wins.
module uni_rr_pick2
  import uni_mem_arb_pkg::*;
(
  input  logic i_valid0,
  input  logic i_valid1,
  input  logic i_last,
  output logic o_grant,
  output logic o_winner
);

  always_comb begin
    o_grant  = i_valid0 | i_valid1;
    o_winner = OWN_D;
    if (i_valid0 && i_valid1) begin
      o_winner = ~i_last;
    end else if (i_valid1) begin
      o_winner = OWN_I;
    end
  end

endmodule

// File: rtl/uni_mem_arb.sv
// Two-master (dCache, iCache) to one-slave arbiter on the uni request bus.
// Grant and request fields are latched so the downstream request is stable.
module uni_mem_arb
  import uni_mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADR_WIDTH,
  parameter int unsigned DATA_W = 128,
  parameter int unsigned SIZE_W = 3
) (
  input  logic              i_clk,
  input  logic              i_rst,

  input  logic              i_d_valid,
  output logic              o_d_ready,
  input  logic              i_d_reqtyp,
  input  logic [ADDR_W-1:0] i_d_addr,
  input  logic [DATA_W-1:0] i_d_wdata,
  input  logic [SIZE_W-1:0] i_d_size,
  input  logic              i_d_cachable,
  output logic [DATA_W-1:0] o_d_rdata,

  input  logic              i_i_valid,
  output logic              o_i_ready,
  input  logic              i_i_reqtyp,
  input  logic [ADDR_W-1:0] i_i_addr,
  input  logic [DATA_W-1:0] i_i_wdata,
  input  logic [SIZE_W-1:0] i_i_size,
  input  logic              i_i_cachable,
  output logic [DATA_W-1:0] o_i_rdata,

  output logic              o_s_valid,
  input  logic              i_s_ready,
  output logic              o_s_reqtyp,
  output logic [ADDR_W-1:0] o_s_addr,
  output logic [DATA_W-1:0] o_s_wdata,
  output logic [SIZE_W-1:0] o_s_size,
  output logic              o_s_cachable,
  input  logic [DATA_W-1:0] i_s_rdata
);

  arb_state_t        state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_q, last_d;
  logic              buf_reqtyp_q, buf_reqtyp_d;
  logic [ADDR_W-1:0] buf_addr_q, buf_addr_d;
  logic [DATA_W-1:0] buf_wdata_q, buf_wdata_d;
  logic [SIZE_W-1:0] buf_size_q, buf_size_d;
  logic              buf_cachable_q, buf_cachable_d;

  logic pick_grant;
  logic pick_winner;
  logic cpl;

  uni_rr_pick2 u_pick (
    .i_valid0 (i_d_valid),
    .i_valid1 (i_i_valid),
    .i_last   (last_q),
    .o_grant  (pick_grant),
    .o_winner (pick_winner)
  );

  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    last_d         = last_q;
    buf_reqtyp_d   = buf_reqtyp_q;
    buf_addr_d     = buf_addr_q;
    buf_wdata_d    = buf_wdata_q;
    buf_size_d     = buf_size_q;
    buf_cachable_d = buf_cachable_q;

    if (state_q == ARB_IDLE) begin
      if (pick_grant) begin
        state_d = ARB_BUSY;
        owner_d = pick_winner;
        if (pick_winner == OWN_I) begin
          buf_reqtyp_d   = i_i_reqtyp;
          buf_addr_d     = i_i_addr;
          buf_wdata_d    = i_i_wdata;
          buf_size_d     = i_i_size;
          buf_cachable_d = i_i_cachable;
        end else begin
          buf_reqtyp_d   = i_d_reqtyp;
          buf_addr_d     = i_d_addr;
          buf_wdata_d    = i_d_wdata;
          buf_size_d     = i_d_size;
          buf_cachable_d = i_d_cachable;
        end
      end
    end else if (i_s_ready) begin
      // Completion always leaves one IDLE cycle before the next grant
      state_d = ARB_IDLE;
      last_d  = owner_q;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q        <= ARB_IDLE;
      owner_q        <= OWN_D;
      last_q         <= OWN_I;
      buf_reqtyp_q   <= '0;
      buf_addr_q     <= '0;
      buf_wdata_q    <= '0;
      buf_size_q     <= '0;
      buf_cachable_q <= '0;
    end else begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      last_q         <= last_d;
      buf_reqtyp_q   <= buf_reqtyp_d;
      buf_addr_q     <= buf_addr_d;
      buf_wdata_q    <= buf_wdata_d;
      buf_size_q     <= buf_size_d;
      buf_cachable_q <= buf_cachable_d;
    end
  end

  always_comb begin
    cpl          = (state_q == ARB_BUSY) && i_s_ready;
    o_s_valid    = (state_q == ARB_BUSY);
    o_s_reqtyp   = buf_reqtyp_q;
    o_s_addr     = buf_addr_q;
    o_s_wdata    = buf_wdata_q;
    o_s_size     = buf_size_q;
    o_s_cachable = buf_cachable_q;
    o_d_ready    = cpl && (owner_q == OWN_D);
    o_i_ready    = cpl && (owner_q == OWN_I);
    o_d_rdata    = o_d_ready ? i_s_rdata : '0;
    o_i_rdata    = o_i_ready ? i_s_rdata : '0;
  end

endmodule
